// File: rtl/hsi_pair_packer.sv
// Serial band-sample packer feeding the HSI vector core: collects vector A then B,
// packs each into a COMPONENTS_MAX-slot word and writes both core FIFOs in lockstep.
module hsi_pair_packer #(
    parameter int COMPONENT_WIDTH = 16,
    parameter int COMPONENTS_MAX  = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      enable,
    input  logic [31:0]                               num_bands,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    input  logic [COMPONENT_WIDTH-1:0]                s_data,
    input  logic                                      s_last,
    output logic                                      in1_wr_en,
    output logic [COMPONENT_WIDTH*COMPONENTS_MAX-1:0] in1_data,
    input  logic                                      in1_full,
    output logic                                      in2_wr_en,
    output logic [COMPONENT_WIDTH*COMPONENTS_MAX-1:0] in2_data,
    input  logic                                      in2_full,
    input  logic                                      clear_err,
    output logic                                      busy,
    output logic [31:0]                               pixel_count,
    output logic [3:0]                                error_code
);

    localparam int PW   = COMPONENT_WIDTH * COMPONENTS_MAX;
    localparam int NB_W = $clog2(COMPONENTS_MAX + 1);
    localparam logic [NB_W-1:0] NB_ONE = NB_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COLLECT_A = 3'd1,
        S_COLLECT_B = 3'd2,
        S_PUSH      = 3'd3,
        S_DRAIN     = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [NB_W-1:0]   r_nb;
    logic [NB_W-1:0]   r_cnt;
    logic [PW-1:0]     r_word_a;
    logic [PW-1:0]     r_word_b;
    logic [PW-1:0]     r_in1_data;
    logic [PW-1:0]     r_in2_data;
    logic [31:0]       r_pixel_count;
    logic [3:0]        r_error;

    logic              w_acc;
    logic              w_last_band;
    logic              w_nb_ok;
    logic              w_frame_err;
    logic              w_push;
    logic              w_clr_words;
    logic              w_to_push;
    logic [PW-1:0]     w_word_a_nxt;
    logic [PW-1:0]     w_word_b_nxt;

    function automatic logic [PW-1:0] band_mask(input logic [NB_W-1:0] nb);
        logic [PW-1:0] m;
        m = '0;
        for (int i = 0; i < COMPONENTS_MAX; i++) begin
            if (i < int'(nb)) m[i*COMPONENT_WIDTH +: COMPONENT_WIDTH] = '1;
        end
        return m;
    endfunction

    // First sample ends up in slot nb-1, last sample in slot 0.
    function automatic logic [PW-1:0] pack_beat(input logic [PW-1:0]              word,
                                                input logic [COMPONENT_WIDTH-1:0] data,
                                                input logic [NB_W-1:0]            nb);
        return ((word << COMPONENT_WIDTH) | PW'(data)) & band_mask(nb);
    endfunction

    assign w_acc        = s_valid && s_ready;
    assign w_last_band  = (r_cnt == (r_nb - NB_ONE));
    assign w_nb_ok      = (num_bands >= 32'd1) && (num_bands <= 32'(COMPONENTS_MAX));
    assign w_push       = (r_state == S_PUSH) && !in1_full && !in2_full;
    assign w_word_a_nxt = pack_beat(r_word_a, s_data, r_nb);
    assign w_word_b_nxt = pack_beat(r_word_b, s_data, r_nb);

    always_comb begin
        w_frame_err = 1'b0;
        if (w_acc) begin
            if (r_state == S_COLLECT_A)
                w_frame_err = s_last;
            else if (r_state == S_COLLECT_B)
                w_frame_err = w_last_band ? !s_last : s_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable && w_nb_ok) w_next = S_COLLECT_A;
            end
            S_COLLECT_A: begin
                if (w_acc && !s_last && w_last_band) w_next = S_COLLECT_B;
            end
            S_COLLECT_B: begin
                if (w_acc) begin
                    if (w_last_band) w_next = s_last ? S_PUSH : S_DRAIN;
                    else if (s_last) w_next = S_COLLECT_A;
                end
            end
            S_PUSH: begin
                if (w_push) w_next = enable ? S_COLLECT_A : S_IDLE;
            end
            S_DRAIN: begin
                if (w_acc && s_last) w_next = S_COLLECT_A;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready   = 1'b0;
        busy      = (r_state != S_IDLE);
        in1_wr_en = 1'b0;
        in2_wr_en = 1'b0;
        case (r_state)
            S_COLLECT_A, S_COLLECT_B, S_DRAIN: s_ready = 1'b1;
            S_PUSH: begin
                in1_wr_en = w_push;
                in2_wr_en = w_push;
            end
            default: ;
        endcase
    end

    assign w_clr_words = (w_next == S_COLLECT_A) && ((r_state != S_COLLECT_A) || w_frame_err);
    assign w_to_push   = (r_state == S_COLLECT_B) && (w_next == S_PUSH);

    // Packers and latched band count; cleared on every fresh start of vector A.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_next == S_COLLECT_A) r_nb <= num_bands[NB_W-1:0];
        if (w_clr_words) begin
            r_word_a <= '0;
            r_word_b <= '0;
        end else begin
            if (r_state == S_COLLECT_A && w_acc) r_word_a <= w_word_a_nxt;
            if (r_state == S_COLLECT_B && w_acc) r_word_b <= w_word_b_nxt;
        end
    end

    // Output words are loaded as the final B beat lands, so they are valid for the whole PUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in1_data <= '0;
            r_in2_data <= '0;
        end else if (w_to_push) begin
            r_in1_data <= r_word_a;
            r_in2_data <= w_word_b_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_pixel_count <= '0;
            r_error       <= '0;
        end else begin
            if (w_clr_words || (r_state != w_next))
                r_cnt <= '0;
            else if (w_acc && (r_state == S_COLLECT_A || r_state == S_COLLECT_B))
                r_cnt <= r_cnt + NB_ONE;

            if (w_push) r_pixel_count <= r_pixel_count + 32'd1;

            if (r_state == S_IDLE && enable && !w_nb_ok) r_error <= 4'd4;
            else if (w_frame_err)                        r_error <= 4'd5;
            else if (clear_err)                          r_error <= 4'd0;
        end
    end

    assign in1_data    = r_in1_data;
    assign in2_data    = r_in2_data;
    assign pixel_count = r_pixel_count;
    assign error_code  = r_error;

endmodule
